// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - IFU/LSU arbiter for one single-beat AXI4 read port (AR/R).
// Round-robin when YSYX_23060251_ARB_RR_EN is defined, otherwise fixed LSU-over-IFU priority.
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int IFU_ID = 0,
  parameter int LSU_ID = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ifu_ar_valid_i,
  input  logic [ADDR_W-1:0] ifu_ar_addr_i,
  output logic              ifu_ar_ready_o,
  output logic              ifu_r_valid_o,
  output logic [DATA_W-1:0] ifu_r_data_o,
  output logic [1:0]        ifu_r_resp_o,
  input  logic              ifu_r_ready_i,
  input  logic              lsu_ar_valid_i,
  input  logic [ADDR_W-1:0] lsu_ar_addr_i,
  output logic              lsu_ar_ready_o,
  output logic              lsu_r_valid_o,
  output logic [DATA_W-1:0] lsu_r_data_o,
  output logic [1:0]        lsu_r_resp_o,
  input  logic              lsu_r_ready_i,
  output logic              mst_ar_valid_o,
  output logic [ADDR_W-1:0] mst_ar_addr_o,
  output logic [ID_W-1:0]   mst_ar_id_o,
  output logic [7:0]        mst_ar_len_o,
  output logic [2:0]        mst_ar_size_o,
  output logic [1:0]        mst_ar_burst_o,
  input  logic              mst_ar_ready_i,
  input  logic              mst_r_valid_i,
  input  logic [DATA_W-1:0] mst_r_data_i,
  input  logic [1:0]        mst_r_resp_i,
  input  logic              mst_r_last_i,
  input  logic [ID_W-1:0]   mst_r_id_i,
  output logic              mst_r_ready_o,
  output logic              busy_o,
  output logic              id_err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2
  } state_t;

  localparam logic [ID_W-1:0] L_IFU_ID = ID_W'(IFU_ID);
  localparam logic [ID_W-1:0] L_LSU_ID = ID_W'(LSU_ID);

  state_t              r_state;
  state_t              w_next_state;
  logic                r_grant;       // 0 = IFU, 1 = LSU
  logic                r_last_grant;
  logic                r_ar_valid;
  logic [ADDR_W-1:0]   r_ar_addr;
  logic [ID_W-1:0]     r_ar_id;
  logic                r_id_err;

  logic w_req_any;
  logic w_pick_lsu;
  logic w_grant_fire;
  logic w_owner_r_ready;
  logic w_r_hs;
  logic w_in_r;

  assign w_req_any = ifu_ar_valid_i | lsu_ar_valid_i;

`ifdef YSYX_23060251_ARB_RR_EN
  // On a tie the requester that did not finish last goes next.
  assign w_pick_lsu = lsu_ar_valid_i & (~ifu_ar_valid_i | ~r_last_grant);
`else
  logic w_unused_last_grant;
  assign w_pick_lsu          = lsu_ar_valid_i;
  assign w_unused_last_grant = r_last_grant;
`endif

  assign w_grant_fire    = (r_state == S_IDLE) & w_req_any;
  assign w_in_r          = (r_state == S_R);
  assign w_owner_r_ready = r_grant ? lsu_r_ready_i : ifu_r_ready_i;
  assign w_r_hs          = mst_r_valid_i & mst_r_ready_o;

  assign ifu_ar_ready_o = w_grant_fire & ~w_pick_lsu;
  assign lsu_ar_ready_o = w_grant_fire & w_pick_lsu;

  assign mst_r_ready_o = w_in_r & w_owner_r_ready;
  assign ifu_r_valid_o = w_in_r & ~r_grant & mst_r_valid_i;
  assign lsu_r_valid_o = w_in_r & r_grant & mst_r_valid_i;
  assign ifu_r_data_o  = mst_r_data_i;
  assign lsu_r_data_o  = mst_r_data_i;
  assign ifu_r_resp_o  = mst_r_resp_i;
  assign lsu_r_resp_o  = mst_r_resp_i;

  assign mst_ar_valid_o = r_ar_valid;
  assign mst_ar_addr_o  = r_ar_addr;
  assign mst_ar_id_o    = r_ar_id;
  assign mst_ar_len_o   = 8'd0;
  assign mst_ar_size_o  = 3'b010;
  assign mst_ar_burst_o = 2'b01;

  assign busy_o   = (r_state != S_IDLE);
  assign id_err_o = r_id_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_req_any) w_next_state = S_AR;
      S_AR:    if (mst_ar_ready_i) w_next_state = S_R;
      // Beats without rlast are delivered but keep us in R.
      S_R:     if (w_r_hs & mst_r_last_i) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_ar_valid   <= 1'b0;
      r_ar_addr    <= '0;
      r_ar_id      <= '0;
      r_id_err     <= 1'b0;
    end else begin
      if (w_grant_fire) begin
        r_grant    <= w_pick_lsu;
        r_ar_valid <= 1'b1;
        r_ar_addr  <= w_pick_lsu ? lsu_ar_addr_i : ifu_ar_addr_i;
        r_ar_id    <= w_pick_lsu ? L_LSU_ID : L_IFU_ID;
      end
      if ((r_state == S_AR) && mst_ar_ready_i) begin
        r_ar_valid <= 1'b0;
      end
      if (w_in_r && w_r_hs && mst_r_last_i) begin
        r_last_grant <= r_grant;
      end
      if (w_in_r && w_r_hs && (mst_r_id_i != r_ar_id)) begin
        r_id_err <= 1'b1;
      end
    end
  end

endmodule
